// File: rtl/sram_responder.sv
// Cycle-accurate on-chip stand-in for a 256K x 16 async SRAM, pin side.
// Define SRAM_RESP_LAST_WR_EN to add last_wr_addr_out/last_wr_data_out.
module sram_responder #(
  parameter int MEM_AW = 12,
  parameter int CNT_W  = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [17:0]      sram_addr_in,
  input  logic             sram_ce_n_in,
  input  logic             sram_oe_n_in,
  input  logic             sram_we_n_in,
  input  logic             sram_lb_n_in,
  input  logic             sram_ub_n_in,
  inout  wire  [15:0]      sram_data_io,
  output logic [CNT_W-1:0] wr_count_out,
  output logic [CNT_W-1:0] rd_count_out,
  output logic             oob_out
`ifdef SRAM_RESP_LAST_WR_EN
  ,
  output logic [17:0]      last_wr_addr_out,
  output logic [15:0]      last_wr_data_out
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WR_ACTIVE,
    RD_ACTIVE
  } state_t;

  state_t state, state_nx;

  logic [17:0] s_addr;
  logic        s_ce_n, s_oe_n, s_we_n;
  logic        s_lb_n, s_ub_n;
  logic [15:0] s_data;

  logic [15:0] mem [0:(1<<MEM_AW)-1];

  logic [MEM_AW-1:0] s_idx, wr_idx;
  logic [15:0]       wr_data;
  logic [1:0]        wr_lanes;
  logic [15:0]       rd_data;
  logic [1:0]        drv_en;

  logic        rd_act, wr_act, oob_hit;
  logic        commit, commit_we;
  logic        rd_load, rd_entry;
  logic [15:0] old_word, merged, rd_word;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s_addr <= '0;
      s_ce_n <= 1'b1;
      s_oe_n <= 1'b1;
      s_we_n <= 1'b1;
      s_lb_n <= 1'b1;
      s_ub_n <= 1'b1;
      s_data <= '0;
    end else begin
      s_addr <= sram_addr_in;
      s_ce_n <= sram_ce_n_in;
      s_oe_n <= sram_oe_n_in;
      s_we_n <= sram_we_n_in;
      s_lb_n <= sram_lb_n_in;
      s_ub_n <= sram_ub_n_in;
      s_data <= sram_data_io;
    end
  end

  always_comb begin
    rd_act  = !s_ce_n && !s_oe_n && s_we_n;
    wr_act  = !s_ce_n && !s_we_n;
    s_idx   = s_addr[MEM_AW-1:0];
    oob_hit = (rd_act || wr_act) &&
              ((s_addr >> MEM_AW) != '0);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (wr_act)
          state_nx = WR_ACTIVE;
        else if (rd_act)
          state_nx = RD_ACTIVE;
      end
      WR_ACTIVE: begin
        if (!wr_act)
          state_nx = rd_act ? RD_ACTIVE : IDLE;
      end
      RD_ACTIVE: begin
        if (wr_act)
          state_nx = WR_ACTIVE;
        else if (!rd_act)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Merged word serves both the commit and same-edge read forwarding.
  always_comb begin
    commit    = (state == WR_ACTIVE) && !wr_act;
    commit_we = commit && (wr_lanes != 2'b00);
    rd_load   = (state_nx == RD_ACTIVE);
    rd_entry  = rd_load && (state != RD_ACTIVE);
    old_word  = mem[wr_idx];
    merged[15:8] = wr_lanes[1] ? wr_data[15:8] : old_word[15:8];
    merged[7:0]  = wr_lanes[0] ? wr_data[7:0]  : old_word[7:0];
    rd_word = mem[s_idx];
    if (commit_we && (wr_idx == s_idx))
      rd_word = merged;
  end

  always_ff @(posedge clk_in) begin
    if (commit_we)
      mem[wr_idx] <= merged;
    if (rd_load)
      rd_data <= rd_word;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      wr_idx       <= '0;
      wr_data      <= '0;
      wr_lanes     <= 2'b00;
      drv_en       <= 2'b00;
      wr_count_out <= '0;
      rd_count_out <= '0;
      oob_out      <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr_act) begin
        wr_idx   <= s_idx;
        wr_data  <= s_data;
        wr_lanes <= {!s_ub_n, !s_lb_n};
      end
      drv_en <= rd_load ? {!s_ub_n, !s_lb_n} : 2'b00;
      if (commit_we && (wr_count_out != '1))
        wr_count_out <= wr_count_out + 1'b1;
      if (rd_entry && (rd_count_out != '1))
        rd_count_out <= rd_count_out + 1'b1;
      if (oob_hit)
        oob_out <= 1'b1;
    end
  end

  assign sram_data_io[7:0]  = drv_en[0] ? rd_data[7:0]  : 8'hzz;
  assign sram_data_io[15:8] = drv_en[1] ? rd_data[15:8] : 8'hzz;

`ifdef SRAM_RESP_LAST_WR_EN
  logic [17:0] wr_addr_full;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_addr_full     <= '0;
      last_wr_addr_out <= '0;
      last_wr_data_out <= '0;
    end else begin
      if (wr_act)
        wr_addr_full <= s_addr;
      if (commit_we) begin
        last_wr_addr_out <= wr_addr_full;
        last_wr_data_out <= merged;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: pins driven on negedge, bus and
// counters sampled on negedge; undriven bus lanes read as 0 via pulldowns.
module tb_sram_responder;

  localparam int AW = 12;
  localparam int CW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [17:0]   addr;
  logic          ce_n, oe_n, we_n, lb_n, ub_n;
  wire  [15:0]   sram_data_io;
  logic          tb_oe;
  logic [15:0]   tb_drv;
  logic [CW-1:0] wr_count_out, rd_count_out;
  logic          oob_out;
`ifdef SRAM_RESP_LAST_WR_EN
  logic [17:0]   last_wr_addr_out;
  logic [15:0]   last_wr_data_out;
`endif

  assign sram_data_io = tb_oe ? tb_drv : 16'hzzzz;

  for (genvar i = 0; i < 16; i++) begin : g_pd
    pulldown pd (sram_data_io[i]);
  end

  sram_responder #(.MEM_AW(AW), .CNT_W(CW)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .sram_addr_in (addr),
    .sram_ce_n_in (ce_n),
    .sram_oe_n_in (oe_n),
    .sram_we_n_in (we_n),
    .sram_lb_n_in (lb_n),
    .sram_ub_n_in (ub_n),
    .sram_data_io (sram_data_io),
    .wr_count_out (wr_count_out),
    .rd_count_out (rd_count_out),
    .oob_out      (oob_out)
`ifdef SRAM_RESP_LAST_WR_EN
    ,
    .last_wr_addr_out (last_wr_addr_out),
    .last_wr_data_out (last_wr_data_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0]   exp_q [$];
  string         name_q [$];
  logic [CW-1:0] exp_wr = '0;
  logic [CW-1:0] exp_rd = '0;

  task automatic step();
    @(negedge clk_in);
  endtask

  task automatic set_idle();
    ce_n  = 1'b1;
    oe_n  = 1'b1;
    we_n  = 1'b1;
    lb_n  = 1'b1;
    ub_n  = 1'b1;
    tb_oe = 1'b0;
  endtask

  task automatic wr(input logic [17:0] a, input logic [15:0] d,
                    input logic lbn, input logic ubn);
    addr = a; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    lb_n = lbn; ub_n = ubn; tb_drv = d; tb_oe = 1'b1;
    step();
    set_idle();
    step();
    step();
    if ((!lbn || !ubn) && exp_wr != '1)
      exp_wr = exp_wr + 1'b1;
  endtask

  task automatic start_read(input logic [17:0] a, input logic lbn,
                            input logic ubn, input logic [15:0] e,
                            input string nm);
    addr = a; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    lb_n = lbn; ub_n = ubn; tb_oe = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (exp_rd != '1)
      exp_rd = exp_rd + 1'b1;
  endtask

  task automatic end_read();
    set_idle();
    step();
    step();
  endtask

  task automatic test_reset();
    step();
    n_checks++;
    if (sram_data_io !== 16'h0000)
      $display("FAIL rst_bus: got %h want 0000", sram_data_io);
    else n_pass++;
    n_checks++;
    if (wr_count_out !== '0 || rd_count_out !== '0)
      $display("FAIL rst_counts: wr=%0d rd=%0d want 0 0",
               wr_count_out, rd_count_out);
    else n_pass++;
    n_checks++;
    if (oob_out !== 1'b0)
      $display("FAIL rst_oob: got %b want 0", oob_out);
    else n_pass++;
    rst_in = 1'b0;
    step();
    step();
    n_checks++;
    if (sram_data_io !== 16'h0000 || wr_count_out !== '0)
      $display("FAIL post_rst: bus=%h wr=%0d want 0000 0",
               sram_data_io, wr_count_out);
    else n_pass++;
  endtask

  task automatic test_lane_write();
    logic [15:0] e;
    string nm;
    wr(18'h00010, 16'h7E7E, 1'b0, 1'b0);
    wr(18'h00010, 16'h00A5, 1'b0, 1'b1);
    start_read(18'h00010, 1'b0, 1'b1, 16'h00A5, "lane_read");
    step();
    n_checks++;
    if (sram_data_io !== 16'h0000)
      $display("FAIL lane_latency: bus=%h want 0000", sram_data_io);
    else n_pass++;
    step();
    e = exp_q.pop_front();
    nm = name_q.pop_front();
    n_checks++;
    if (sram_data_io !== e)
      $display("FAIL %s: bus=%h want %h", nm, sram_data_io, e);
    else n_pass++;
    n_checks++;
    if (wr_count_out !== exp_wr || rd_count_out !== exp_rd)
      $display("FAIL lane_counts: wr=%0d rd=%0d want %0d %0d",
               wr_count_out, rd_count_out, exp_wr, exp_rd);
    else n_pass++;
    end_read();
    n_checks++;
    if (sram_data_io !== 16'h0000)
      $display("FAIL lane_release: bus=%h want 0000", sram_data_io);
    else n_pass++;
  endtask

  task automatic test_byte_merge();
    logic [15:0] e;
    string nm;
    wr(18'h5, 16'h1234, 1'b0, 1'b0);
    wr(18'h5, 16'hAB00, 1'b1, 1'b0);
    start_read(18'h5, 1'b0, 1'b0, 16'hAB34, "merge_read");
    step();
    step();
    e = exp_q.pop_front();
    nm = name_q.pop_front();
    n_checks++;
    if (sram_data_io !== e)
      $display("FAIL %s: bus=%h want %h", nm, sram_data_io, e);
    else n_pass++;
    end_read();
  endtask

  task automatic test_no_lane_write();
    logic [15:0] e;
    string nm;
    wr(18'h5, 16'hFFFF, 1'b1, 1'b1);
    n_checks++;
    if (wr_count_out !== exp_wr)
      $display("FAIL nolane_count: wr=%0d want %0d", wr_count_out, exp_wr);
    else n_pass++;
    start_read(18'h5, 1'b0, 1'b0, 16'hAB34, "nolane_read");
    step();
    step();
    e = exp_q.pop_front();
    nm = name_q.pop_front();
    n_checks++;
    if (sram_data_io !== e)
      $display("FAIL %s: bus=%h want %h", nm, sram_data_io, e);
    else n_pass++;
    end_read();
  endtask

  task automatic test_forward();
    logic [15:0] e;
    string nm;
    wr(18'h7, 16'h1111, 1'b0, 1'b0);
    addr = 18'h7; ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    lb_n = 1'b0; ub_n = 1'b0; tb_drv = 16'hBEEF; tb_oe = 1'b1;
    step();
    if (exp_wr != '1)
      exp_wr = exp_wr + 1'b1;
    start_read(18'h7, 1'b0, 1'b0, 16'hBEEF, "fwd_read");
    step();
    step();
    e = exp_q.pop_front();
    nm = name_q.pop_front();
    n_checks++;
    if (sram_data_io !== e)
      $display("FAIL %s: bus=%h want %h", nm, sram_data_io, e);
    else n_pass++;
    n_checks++;
    if (wr_count_out !== exp_wr)
      $display("FAIL fwd_count: wr=%0d want %0d", wr_count_out, exp_wr);
    else n_pass++;
`ifdef SRAM_RESP_LAST_WR_EN
    n_checks++;
    if (last_wr_addr_out !== 18'h7 || last_wr_data_out !== 16'hBEEF)
      $display("FAIL last_wr: addr=%h data=%h want 00007 beef",
               last_wr_addr_out, last_wr_data_out);
    else n_pass++;
`endif
    end_read();
  endtask

  task automatic test_oob();
    logic [15:0] e;
    string nm;
    n_checks++;
    if (oob_out !== 1'b0)
      $display("FAIL oob_pre: got %b want 0", oob_out);
    else n_pass++;
    wr(18'h01000, 16'h0C0C, 1'b0, 1'b0);
    n_checks++;
    if (oob_out !== 1'b1)
      $display("FAIL oob_set: got %b want 1", oob_out);
    else n_pass++;
    start_read(18'h00000, 1'b0, 1'b0, 16'h0C0C, "oob_alias");
    step();
    step();
    e = exp_q.pop_front();
    nm = name_q.pop_front();
    n_checks++;
    if (sram_data_io !== e)
      $display("FAIL %s: bus=%h want %h", nm, sram_data_io, e);
    else n_pass++;
    end_read();
    n_checks++;
    if (oob_out !== 1'b1)
      $display("FAIL oob_sticky: got %b want 1", oob_out);
    else n_pass++;
  endtask

  task automatic test_oe_we_overlap();
    logic [15:0] e;
    string nm;
    wr(18'h9, 16'h0101, 1'b0, 1'b0);
    addr = 18'h9; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0;
    lb_n = 1'b0; ub_n = 1'b0; tb_oe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (sram_data_io !== 16'h0000)
        $display("FAIL ovl_bus%0d: bus=%h want 0000", i, sram_data_io);
      else n_pass++;
    end
    tb_drv = 16'h6969;
    tb_oe  = 1'b1;
    step();
    set_idle();
    for (int i = 2; i < 4; i++) begin
      step();
      n_checks++;
      if (sram_data_io !== 16'h0000)
        $display("FAIL ovl_bus%0d: bus=%h want 0000", i, sram_data_io);
      else n_pass++;
    end
    if (exp_wr != '1)
      exp_wr = exp_wr + 1'b1;
    n_checks++;
    if (wr_count_out !== exp_wr || rd_count_out !== exp_rd)
      $display("FAIL ovl_counts: wr=%0d rd=%0d want %0d %0d",
               wr_count_out, rd_count_out, exp_wr, exp_rd);
    else n_pass++;
    start_read(18'h9, 1'b0, 1'b0, 16'h6969, "ovl_read");
    step();
    step();
    e = exp_q.pop_front();
    nm = name_q.pop_front();
    n_checks++;
    if (sram_data_io !== e)
      $display("FAIL %s: bus=%h want %h", nm, sram_data_io, e);
    else n_pass++;
    end_read();
  endtask

  task automatic test_reset_mid();
    logic [15:0] e;
    string nm;
    wr(18'h3, 16'h3C3C, 1'b0, 1'b0);
    start_read(18'h3, 1'b0, 1'b0, 16'h3C3C, "pre_rst_read");
    step();
    step();
    e = exp_q.pop_front();
    nm = name_q.pop_front();
    n_checks++;
    if (sram_data_io !== e)
      $display("FAIL %s: bus=%h want %h", nm, sram_data_io, e);
    else n_pass++;
    #2 rst_in = 1'b1;
    #1;
    exp_wr = '0;
    exp_rd = '0;
    n_checks++;
    if (sram_data_io !== 16'h0000)
      $display("FAIL rst_rd_bus: bus=%h want 0000", sram_data_io);
    else n_pass++;
    n_checks++;
    if (wr_count_out !== '0 || rd_count_out !== '0 || oob_out !== 1'b0)
      $display("FAIL rst_mid_state: wr=%0d rd=%0d oob=%b want 0 0 0",
               wr_count_out, rd_count_out, oob_out);
    else n_pass++;
    step();
    set_idle();
    step();
    rst_in = 1'b0;
    addr = 18'h3; ce_n = 1'b0; we_n = 1'b0;
    lb_n = 1'b0; ub_n = 1'b0; tb_drv = 16'h5555; tb_oe = 1'b1;
    step();
    step();
    #2 rst_in = 1'b1;
    #1;
    n_checks++;
    if (sram_data_io !== 16'h5555)
      $display("FAIL rst_wr_bus: bus=%h want 5555", sram_data_io);
    else n_pass++;
    step();
    set_idle();
    step();
    rst_in = 1'b0;
    step();
    step();
    n_checks++;
    if (wr_count_out !== '0 || sram_data_io !== 16'h0000)
      $display("FAIL rst_wr_state: wr=%0d bus=%h want 0 0000",
               wr_count_out, sram_data_io);
    else n_pass++;
    start_read(18'h3, 1'b0, 1'b0, 16'h3C3C, "rst_wr_kept");
    step();
    step();
    e = exp_q.pop_front();
    nm = name_q.pop_front();
    n_checks++;
    if (sram_data_io !== e)
      $display("FAIL %s: bus=%h want %h", nm, sram_data_io, e);
    else n_pass++;
    end_read();
  endtask

  task automatic test_saturation();
    logic [15:0] e;
    string nm;
    for (int i = 0; i < 17; i++)
      wr(18'h100 + 18'(i), 16'hA000 + 16'(i), 1'b0, 1'b0);
    n_checks++;
    if (wr_count_out !== exp_wr || exp_wr !== 4'hF)
      $display("FAIL wr_sat: wr=%0d want %0d", wr_count_out, exp_wr);
    else n_pass++;
    for (int i = 0; i < 17; i++) begin
      start_read(18'h100 + 18'(i), 1'b0, 1'b0,
                 16'hA000 + 16'(i), "sat_read");
      step();
      step();
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (sram_data_io !== e)
        $display("FAIL %s%0d: bus=%h want %h", nm, i, sram_data_io, e);
      else n_pass++;
      end_read();
    end
    n_checks++;
    if (rd_count_out !== exp_rd || exp_rd !== 4'hF)
      $display("FAIL rd_sat: rd=%0d want %0d", rd_count_out, exp_rd);
    else n_pass++;
  endtask

  initial begin
    addr   = '0;
    tb_drv = '0;
    set_idle();
    test_reset();
    test_lane_write();
    test_byte_merge();
    test_no_lane_write();
    test_forward();
    test_oob();
    test_oe_we_overlap();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, passed=%0d total=%0d",
             n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
